// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: launches the multi-cycle unit from DX, stalls
// the pipe, and returns a single writeback (result or $rstatus code).
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT      = 40,
  parameter int unsigned TIMEOUT_CODE = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_insn,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_e;

  localparam logic [4:0] RSTATUS = 5'd30;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] res_q;
  logic [4:0]  rd_q;
  logic        div_q;
  logic        exc_q;
  logic        tmo_q;

  logic        is_md;
  logic        insn_div;
  logic        launch;
  logic        unused_insn;

  // mul = 00110, div = 00111: both share [6:3]
  assign is_md    = (dx_insn[31:27] == 5'd0) &&
                    (dx_insn[6:3] == 4'b0011);
  assign insn_div = dx_insn[2];
  assign launch   = (state_q == IDLE) && is_md && !flush;

  assign unused_insn = ^{dx_insn[21:7], dx_insn[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            opa_q   <= dx_opA;
            opb_q   <= dx_opB;
            rd_q    <= dx_insn[26:22];
            div_q   <= insn_div;
            state_q <= START;
          end
        end
        START: begin
          cnt_q <= '0;
          exc_q <= 1'b0;
          tmo_q <= 1'b0;
          res_q <= '0;
          if (flush) begin
            state_q <= IDLE;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (md_resultRDY) begin
            res_q   <= md_result;
            exc_q   <= md_exception;
            state_q <= DONE;
          end else if (cnt_q == CNT_MAX) begin
            tmo_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Start pulses and writeback decode straight from registered state
  always_comb begin
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    if (state_q == DONE) begin
      if (tmo_q) begin
        wb_reg  = RSTATUS;
        wb_data = 32'(TIMEOUT_CODE);
      end else if (exc_q) begin
        wb_reg  = RSTATUS;
        wb_data = div_q ? 32'd5 : 32'd4;
      end else begin
        wb_reg  = rd_q;
        wb_data = res_q;
      end
      wb_valid = (wb_reg != 5'd0);
    end
  end

  assign ctrl_MULT   = (state_q == START) && !div_q;
  assign ctrl_DIV    = (state_q == START) && div_q;
  assign md_operandA = opa_q;
  assign md_operandB = opb_q;
  assign stall       = !reset && (launch ||
                                  (state_q == START) ||
                                  (state_q == BUSY));

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: launch, exceptions, rd=0,
// flush abort, timeout, back-to-back and reset mid-operation.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] dx_insn;
  logic [31:0] dx_opA;
  logic [31:0] dx_opB;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(
    .TIMEOUT(40),
    .TIMEOUT_CODE(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dx_insn(dx_insn),
    .dx_opA(dx_opA),
    .dx_opB(dx_opB),
    .flush(flush),
    .md_result(md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .md_operandA(md_operandA),
    .md_operandB(md_operandB),
    .stall(stall),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] rd,
                                     input logic div);
    return {5'd0, rd, 15'd0, 4'b0011, div, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Runs detect, START and BUSY; returns in the DONE cycle.
  task automatic do_op(input string tag, input logic [4:0] rd,
                       input logic div, input logic [31:0] a,
                       input logic [31:0] b, input int rdy_at,
                       input logic [31:0] res, input logic exc,
                       output int stalls);
    dx_insn = mk(rd, div);
    dx_opA  = a;
    dx_opB  = b;
    #1;
    stalls = int'(stall);
    next();
    chk({tag, ".mulpulse"}, 32'(ctrl_MULT), 32'(!div));
    chk({tag, ".divpulse"}, 32'(ctrl_DIV), 32'(div));
    stalls += int'(stall);
    for (int i = 1; i <= rdy_at; i++) begin
      next();
      if (i == rdy_at) begin
        md_resultRDY = 1'b1;
        md_result    = res;
        md_exception = exc;
      end
      stalls += int'(stall);
    end
    next();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;
  endtask

  int st;
  int n;
  int pulses;

  initial begin
    reset = 1'b1;
    dx_insn = '0;
    dx_opA = '0;
    dx_opB = '0;
    flush = 1'b0;
    md_result = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    next();
    next();
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.mul", 32'(ctrl_MULT), 32'd0);
    chk("rst.wbv", 32'(wb_valid), 32'd0);
    chk("rst.opA", md_operandA, 32'd0);
    reset = 1'b0;
    next();

    // mul r5 = 7*6, ready on 3rd BUSY cycle
    do_op("mul5", 5'd5, 1'b0, 32'd7, 32'd6, 3, 32'd42, 1'b0, st);
    chk("mul5.stalls", 32'(st), 32'd5);
    chk("mul5.opA", md_operandA, 32'd7);
    chk("mul5.opB", md_operandB, 32'd6);
    chk("mul5.wbv", 32'(wb_valid), 32'd1);
    chk("mul5.reg", 32'(wb_reg), 32'd5);
    chk("mul5.data", wb_data, 32'd42);
    chk("mul5.dstall", 32'(stall), 32'd0);
    chk("mul5.nodiv", 32'(ctrl_DIV), 32'd0);
    next();
    dx_insn = '0;
    #1;
    chk("mul5.idlewbv", 32'(wb_valid), 32'd0);
    chk("mul5.idledata", wb_data, 32'd0);

    // div by zero
    do_op("div0", 5'd3, 1'b1, 32'd9, 32'd0, 1, 32'd0, 1'b1, st);
    chk("div0.stalls", 32'(st), 32'd3);
    chk("div0.wbv", 32'(wb_valid), 32'd1);
    chk("div0.reg", 32'(wb_reg), 32'd30);
    chk("div0.data", wb_data, 32'd5);
    next();
    dx_insn = '0;

    // mul overflow
    do_op("movf", 5'd8, 1'b0, 32'hffff, 32'hffff, 2, 32'd0, 1'b1, st);
    chk("movf.reg", 32'(wb_reg), 32'd30);
    chk("movf.data", wb_data, 32'd4);
    next();
    dx_insn = '0;

    // rd = 0 suppresses the write
    do_op("rd0", 5'd0, 1'b0, 32'd3, 32'd33, 1, 32'd99, 1'b0, st);
    chk("rd0.stalls", 32'(st), 32'd3);
    chk("rd0.wbv", 32'(wb_valid), 32'd0);
    chk("rd0.reg", 32'(wb_reg), 32'd0);
    next();
    dx_insn = '0;

    // flush in the detect cycle squashes the launch
    dx_insn = mk(5'd4, 1'b0);
    flush = 1'b1;
    #1;
    chk("fdet.stall", 32'(stall), 32'd0);
    next();
    flush = 1'b0;
    dx_insn = '0;
    #1;
    chk("fdet.mul", 32'(ctrl_MULT), 32'd0);

    // flush in 2nd BUSY, stale ready 2 cycles later
    dx_insn = mk(5'd7, 1'b0);
    dx_opA = 32'd11;
    next();
    next();
    next();
    flush = 1'b1;
    #1;
    chk("fl.busystall", 32'(stall), 32'd1);
    next();
    flush = 1'b0;
    dx_insn = '0;
    #1;
    chk("fl.stall", 32'(stall), 32'd0);
    next();
    md_resultRDY = 1'b1;
    md_result = 32'd77;
    next();
    md_resultRDY = 1'b0;
    #1;
    chk("fl.wbv", 32'(wb_valid), 32'd0);
    chk("fl.stall2", 32'(stall), 32'd0);
    next();
    chk("fl.wbv2", 32'(wb_valid), 32'd0);
    chk("fl.mul", 32'(ctrl_MULT), 32'd0);

    // timeout: ready never comes
    dx_insn = mk(5'd9, 1'b0);
    next();
    n = 0;
    st = 0;
    pulses = 0;
    while (n < 100) begin
      next();
      n++;
      if (wb_valid) break;
      st += int'(stall);
    end
    chk("tmo.cycles", 32'(n), 32'd41);
    chk("tmo.busy", 32'(st), 32'd40);
    chk("tmo.reg", 32'(wb_reg), 32'd30);
    chk("tmo.data", wb_data, 32'd6);
    next();
    dx_insn = '0;

    // back-to-back div then mul, reset in the mul's BUSY
    do_op("bdiv", 5'd4, 1'b1, 32'd100, 32'd7, 2, 32'd14, 1'b0, st);
    chk("bdiv.reg", 32'(wb_reg), 32'd4);
    chk("bdiv.data", wb_data, 32'd14);
    chk("bdiv.dstall", 32'(stall), 32'd0);
    next();
    dx_insn = mk(5'd6, 1'b0);
    dx_opA = 32'd3;
    dx_opB = 32'd5;
    #1;
    chk("b2b.detect", 32'(stall), 32'd1);
    next();
    chk("b2b.mul", 32'(ctrl_MULT), 32'd1);
    chk("b2b.opA", md_operandA, 32'd3);
    next();
    reset = 1'b1;
    #1;
    chk("rmid.stall", 32'(stall), 32'd0);
    chk("rmid.opA", md_operandA, 32'd0);
    chk("rmid.opB", md_operandB, 32'd0);
    chk("rmid.wbv", 32'(wb_valid), 32'd0);
    dx_insn = '0;
    next();
    reset = 1'b0;
    next();
    md_resultRDY = 1'b1;
    md_result = 32'd15;
    next();
    md_resultRDY = 1'b0;
    #1;
    chk("rmid.late", 32'(wb_valid), 32'd0);
    chk("rmid.stall2", 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer between the decode/execute stage and the multi-cycle multiplier/divider. Detects `mul`/`div` in the DX latch, latches operands and destination, pulses the unit's start control, and stalls the pipeline until the result is ready or a timeout occurs. It then issues a single writeback request, either the result to `$rd` or an exception code to `$rstatus` (r30). Sits beside the execute stage; its writeback request is merged into the regfile write port by the writeback mux.

## Interface
- TIMEOUT, 40, BUSY cycles allowed before forcing a timeout exception (range 2..255)
- TIMEOUT_CODE, 6, value written to r30 on timeout

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- dx_insn  in  32  instruction in DX latch
- dx_opA  in  32  forwarded operand A for the DX instruction
- dx_opB  in  32  forwarded operand B for the DX instruction
- flush  in  1  branch/jump squash of DX
- md_result  in  32  multdiv result
- md_exception  in  1  multdiv overflow / divide-by-zero
- md_resultRDY  in  1  multdiv done (single-cycle pulse)
- ctrl_MULT  out  1  one-cycle start pulse to multiplier
- ctrl_DIV  out  1  one-cycle start pulse to divider
- md_operandA  out  32  latched operand A
- md_operandB  out  32  latched operand B
- stall  out  1  freeze PC/FD/DX latches
- wb_valid  out  1  one-cycle regfile write request
- wb_reg  out  5  write destination
- wb_data  out  32  write data

## Operation
- Decode: `is_md` = (dx_insn[31:27]==00000) & (dx_insn[6:2]==00110 mul | 00111 div).
- States: IDLE, START, BUSY, DONE.
- IDLE: if `is_md` & !flush, latch opA/opB, rd=dx_insn[26:22], op (mul/div), then go to START. Otherwise stay.
- START: assert ctrl_MULT or ctrl_DIV per latched op (exactly one), clear the cycle counter, go to BUSY. md_resultRDY in START is ignored.
- BUSY: counter increments each cycle.
  - md_resultRDY: capture md_result and md_exception, go to DONE.
  - counter == TIMEOUT-1 with no ready: set the timeout flag, go to DONE.
- DONE: drive the writeback request for one cycle, then return to IDLE. `is_md` is ignored in DONE.
- Writeback data in DONE:
  - Timeout: wb_reg=30, wb_data=TIMEOUT_CODE.
  - md_exception: wb_reg=30, wb_data = 4 for mul, 5 for div.
  - Otherwise: wb_reg=rd, wb_data=captured result.
- wb_valid in DONE = 1, except when wb_reg would be 0 (rd=0, no exception), where it is 0.
- flush in START or BUSY: go to IDLE, no writeback, stall drops next cycle. A later md_resultRDY from the aborted op arriving in IDLE is ignored. flush has priority over md_resultRDY in the same cycle.
- md_operandA/B hold their latched values from IDLE→START until the next launch.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0, latched regs 0.
- stall = (IDLE & is_md & !flush) | START | BUSY. It is combinational so the first stall cycle is the detect cycle. It is 0 in DONE, so the DX instruction advances at the end of DONE.
- Start pulse is registered behaviour: asserted exactly one cycle after detect.
- Minimum latency, detect to wb_valid: with resultRDY in the first BUSY cycle, DONE is cycle 3 (detect=0, START=1, BUSY=2, DONE=3).
- wb_valid, wb_reg and wb_data are valid only in DONE and are 0 elsewhere.
- Back-to-back mul/div: a second `is_md` in DX is detected in the IDLE cycle immediately after DONE.
- Reset mid-operation: immediate return to IDLE, outputs 0, and any later resultRDY is ignored.

## Test plan
- mul, rd=5, A=7, B=6, resultRDY with 42 on the 3rd BUSY cycle:
  - stall high for 5 cycles, ctrl_MULT pulses once at cycle 1.
  - DONE: wb_valid=1, wb_reg=5, wb_data=42. No ctrl_DIV.
- div, rd=3, B=0, resultRDY with md_exception=1: wb_reg=30, wb_data=5. mul overflow variant gives wb_data=4.
- mul with rd=0 and valid result: stall sequence is normal, wb_valid stays 0.
- flush in 2nd BUSY cycle, then resultRDY 2 cycles later: FSM in IDLE, stall 0 after the flush, no wb_valid.
- resultRDY never arrives, TIMEOUT=40: DONE occurs after 40 BUSY cycles, with wb_reg=30, wb_data=6.
- Back-to-back div then mul with reset asserted in the BUSY of the mul:
  - div completes normally.
  - On reset, all outputs are 0 immediately and state is IDLE.
